// File: rtl/acc_pkg.sv
// Shared types for the accelerator dispatcher: queue entry payload sized for the
// widest supported configuration; instances truncate to their own parameters.
package acc_pkg;

    localparam int unsigned AccMaxXlen    = 64;
    localparam int unsigned AccMaxTidBits = 8;
    localparam int unsigned AccMaxChW     = 8;

    typedef struct packed {
        logic [31:0]              insn;
        logic [AccMaxXlen-1:0]    rs1;
        logic [AccMaxXlen-1:0]    rs2;
        logic [AccMaxTidBits-1:0] trans_id;
        logic [AccMaxChW-1:0]     chan;
        logic                     is_ld;
        logic                     is_st;
    } acc_disp_entry_t;

endpackage

// File: rtl/acc_sat_counter.sv
// Saturating up/down counter with sticky error on overflow or underflow.
module acc_sat_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] q_o,
    output logic             err_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign q_o   = cnt_q;
    assign err_o = err_q;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i) begin
            if (cnt_q == {WIDTH{1'b1}}) err_d = 1'b1;
            else                        cnt_d = cnt_q + WIDTH'(1);
        end else if (dec_i && !inc_i) begin
            if (cnt_q == '0) err_d = 1'b1;
            else             cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/fifo_v3.sv
// Synchronous FIFO with optional fall-through, common_cells fifo_v3 port subset.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic,
    localparam int unsigned ADDR_DEPTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    logic [ADDR_DEPTH-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
    logic                  do_write;
    dtype                  mem_q [DEPTH];

    assign full_o  = (cnt_q == (ADDR_DEPTH+1)'(DEPTH));
    assign empty_o = (cnt_q == '0) & ~(FALL_THROUGH & push_i);
    assign usage_o = cnt_q[ADDR_DEPTH-1:0];
    assign data_o  = (FALL_THROUGH && cnt_q == '0) ? data_i : mem_q[rd_q];

    always_comb begin
        rd_d     = rd_q;
        wr_d     = wr_q;
        cnt_d    = cnt_q;
        do_write = 1'b0;
        if (push_i && !full_o) begin
            do_write = 1'b1;
            wr_d     = (wr_q == ADDR_DEPTH'(DEPTH - 1)) ? '0 : wr_q + ADDR_DEPTH'(1);
            cnt_d    = cnt_q + (ADDR_DEPTH+1)'(1);
        end
        if (pop_i && !empty_o) begin
            rd_d  = (rd_q == ADDR_DEPTH'(DEPTH - 1)) ? '0 : rd_q + ADDR_DEPTH'(1);
            cnt_d = cnt_d - (ADDR_DEPTH+1)'(1);
        end
        // bypassed element never lands in storage
        if (FALL_THROUGH && cnt_q == '0 && push_i && pop_i) begin
            do_write = 1'b0;
            wr_d     = wr_q;
            rd_d     = rd_q;
            cnt_d    = cnt_q;
        end
        if (flush_i) begin
            do_write = 1'b0;
            rd_d     = '0;
            wr_d     = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_write) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/acc_multi_dispatcher.sv
// In-order accelerator dispatcher: queues issued instructions, releases each once
// non-speculative, and routes it to one of several accelerator request channels.
module acc_multi_dispatcher
    import acc_pkg::*;
#(
    parameter int unsigned NrChannels    = 2,
    parameter int unsigned QueueDepth    = 4,
    parameter int unsigned NrSbEntries   = 8,
    parameter int unsigned NrCommitPorts = 2,
    parameter int unsigned CntWidth      = 3,
    parameter int unsigned XLEN          = 64,
    localparam int unsigned ChW          = (NrChannels > 1) ? $clog2(NrChannels) : 1,
    localparam int unsigned TransIdBits  = $clog2(NrSbEntries)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     flush_i,
    input  logic                                     issue_valid_i,
    output logic                                     issue_ready_o,
    input  logic [31:0]                              issue_insn_i,
    input  logic [XLEN-1:0]                          issue_rs1_i,
    input  logic [XLEN-1:0]                          issue_rs2_i,
    input  logic [TransIdBits-1:0]                   issue_trans_id_i,
    input  logic [ChW-1:0]                           issue_chan_i,
    input  logic                                     issue_is_ld_i,
    input  logic                                     issue_is_st_i,
    input  logic [NrCommitPorts-1:0]                 commit_acc_i,
    input  logic [NrCommitPorts-1:0][TransIdBits-1:0] commit_trans_id_i,
    input  logic                                     commit_st_barrier_i,
    output logic [NrChannels-1:0]                    acc_req_valid_o,
    input  logic [NrChannels-1:0]                    acc_req_ready_i,
    output logic [NrChannels-1:0][31:0]              acc_req_insn_o,
    output logic [NrChannels-1:0][XLEN-1:0]          acc_req_rs1_o,
    output logic [NrChannels-1:0][XLEN-1:0]          acc_req_rs2_o,
    output logic [NrChannels-1:0][TransIdBits-1:0]   acc_req_trans_id_o,
    input  logic [NrChannels-1:0]                    acc_ld_complete_i,
    input  logic [NrChannels-1:0]                    acc_st_complete_i,
    input  logic                                     cons_en_i,
    input  logic                                     scalar_ld_i,
    input  logic                                     scalar_st_i,
    output logic                                     scalar_stall_o,
    output logic                                     halt_o,
    output logic                                     err_o
);

    localparam int unsigned QAddrW = $clog2(QueueDepth);

    acc_disp_entry_t         push_entry, head;
    logic                    fifo_full, fifo_empty;
    logic [QAddrW-1:0]       fifo_usage;
    logic                    issue_fire, dispatch, chan_free;
    logic [TransIdBits-1:0]  head_tid, marker_tid;
    logic [ChW-1:0]          head_chan;
    logic                    marker_vld, marker_hit;
    logic [NrSbEntries-1:0]  pending_q, pending_d, nonspec_q, nonspec_d;
    logic                    halt_q, halt_d;
    logic                    unused_bits;

    logic [NrChannels-1:0]                  req_valid_q, req_valid_d;
    logic [NrChannels-1:0][31:0]            req_insn_q, req_insn_d;
    logic [NrChannels-1:0][XLEN-1:0]        req_rs1_q, req_rs1_d, req_rs2_q, req_rs2_d;
    logic [NrChannels-1:0][TransIdBits-1:0] req_tid_q, req_tid_d;

    logic [NrChannels-1:0][CntWidth-1:0] spec_ld_cnt, spec_st_cnt, disp_ld_cnt, disp_st_cnt;
    logic [NrChannels-1:0][3:0]          cnt_err;
    logic                                ldp, stp;

    assign issue_ready_o = ~fifo_full;
    assign issue_fire    = issue_valid_i & issue_ready_o & ~flush_i;

    always_comb begin
        push_entry          = '0;
        push_entry.insn     = issue_insn_i;
        push_entry.rs1      = AccMaxXlen'(issue_rs1_i);
        push_entry.rs2      = AccMaxXlen'(issue_rs2_i);
        push_entry.trans_id = AccMaxTidBits'(issue_trans_id_i);
        push_entry.chan     = AccMaxChW'(issue_chan_i);
        push_entry.is_ld    = issue_is_ld_i;
        push_entry.is_st    = issue_is_st_i;
    end

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DEPTH        (QueueDepth),
        .dtype        (acc_disp_entry_t)
    ) i_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (fifo_usage),
        .data_i  (push_entry),
        .push_i  (issue_fire),
        .data_o  (head),
        .pop_i   (dispatch)
    );

    assign unused_bits = ^{head, fifo_usage};
    assign head_tid    = TransIdBits'(head.trans_id);
    assign head_chan   = ChW'(head.chan);

    // lowest commit port carrying an accelerator instruction is the marker
    always_comb begin
        marker_vld = 1'b0;
        marker_tid = '0;
        for (int p = int'(NrCommitPorts) - 1; p >= 0; p--) begin
            if (commit_acc_i[p]) begin
                marker_vld = 1'b1;
                marker_tid = commit_trans_id_i[p];
            end
        end
    end

    assign marker_hit = marker_vld & pending_q[marker_tid];
    assign chan_free  = ~req_valid_q[head_chan] | acc_req_ready_i[head_chan];
    assign dispatch   = ~fifo_empty & ~flush_i & chan_free &
                        (nonspec_q[head_tid] | (marker_hit & (marker_tid == head_tid)));

    always_comb begin
        pending_d = pending_q;
        nonspec_d = nonspec_q;
        if (marker_hit) begin
            pending_d[marker_tid] = 1'b0;
            nonspec_d[marker_tid] = 1'b1;
        end
        if (issue_fire) pending_d[issue_trans_id_i] = 1'b1;
        if (dispatch)   nonspec_d[head_tid] = 1'b0;
        if (flush_i) begin
            pending_d = '0;
            nonspec_d = '0;
        end
    end

    // request registers hold until their own handshake; a dispatch may refill in the same cycle
    always_comb begin
        req_valid_d = req_valid_q;
        req_insn_d  = req_insn_q;
        req_rs1_d   = req_rs1_q;
        req_rs2_d   = req_rs2_q;
        req_tid_d   = req_tid_q;
        for (int c = 0; c < int'(NrChannels); c++) begin
            if (acc_req_ready_i[c]) req_valid_d[c] = 1'b0;
            if (dispatch && head_chan == ChW'(c)) begin
                req_valid_d[c] = 1'b1;
                req_insn_d[c]  = head.insn;
                req_rs1_d[c]   = XLEN'(head.rs1);
                req_rs2_d[c]   = XLEN'(head.rs2);
                req_tid_d[c]   = head_tid;
            end
        end
    end

    assign ldp    = (|spec_ld_cnt) | (|disp_ld_cnt);
    assign stp    = (|spec_st_cnt) | (|disp_st_cnt);
    assign halt_d = (halt_q | commit_st_barrier_i) & stp;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q   <= '0;
            nonspec_q   <= '0;
            halt_q      <= 1'b0;
            req_valid_q <= '0;
            req_insn_q  <= '0;
            req_rs1_q   <= '0;
            req_rs2_q   <= '0;
            req_tid_q   <= '0;
        end else begin
            pending_q   <= pending_d;
            nonspec_q   <= nonspec_d;
            halt_q      <= halt_d;
            req_valid_q <= req_valid_d;
            req_insn_q  <= req_insn_d;
            req_rs1_q   <= req_rs1_d;
            req_rs2_q   <= req_rs2_d;
            req_tid_q   <= req_tid_d;
        end
    end

    for (genvar c = 0; c < NrChannels; c++) begin : g_chan
        logic issue_c, disp_c;
        assign issue_c = issue_fire & (issue_chan_i == ChW'(c));
        assign disp_c  = dispatch & (head_chan == ChW'(c));

        acc_sat_counter #(.WIDTH(CntWidth)) i_spec_ld (
            .clk_i, .rst_ni, .clr_i(flush_i),
            .inc_i(issue_c & issue_is_ld_i), .dec_i(disp_c & head.is_ld),
            .q_o(spec_ld_cnt[c]), .err_o(cnt_err[c][0])
        );
        acc_sat_counter #(.WIDTH(CntWidth)) i_spec_st (
            .clk_i, .rst_ni, .clr_i(flush_i),
            .inc_i(issue_c & issue_is_st_i), .dec_i(disp_c & head.is_st),
            .q_o(spec_st_cnt[c]), .err_o(cnt_err[c][1])
        );
        acc_sat_counter #(.WIDTH(CntWidth)) i_disp_ld (
            .clk_i, .rst_ni, .clr_i(1'b0),
            .inc_i(disp_c & head.is_ld), .dec_i(acc_ld_complete_i[c]),
            .q_o(disp_ld_cnt[c]), .err_o(cnt_err[c][2])
        );
        acc_sat_counter #(.WIDTH(CntWidth)) i_disp_st (
            .clk_i, .rst_ni, .clr_i(1'b0),
            .inc_i(disp_c & head.is_st), .dec_i(acc_st_complete_i[c]),
            .q_o(disp_st_cnt[c]), .err_o(cnt_err[c][3])
        );
    end

    assign acc_req_valid_o    = req_valid_q;
    assign acc_req_insn_o     = req_insn_q;
    assign acc_req_rs1_o      = req_rs1_q;
    assign acc_req_rs2_o      = req_rs2_q;
    assign acc_req_trans_id_o = req_tid_q;
    assign halt_o             = halt_q;
    assign err_o              = |cnt_err;
    assign scalar_stall_o     = cons_en_i & ((scalar_ld_i & stp) | (scalar_st_i & (ldp | stp)));

endmodule

// File: tb/tb_acc_multi_dispatcher.sv
// Directed bench for acc_multi_dispatcher with a queue-based reference model
// checked every cycle, plus hand-computed spot checks.
module tb_acc_multi_dispatcher;

    localparam int NCH = 2;
    localparam int QD  = 4;
    localparam int NSB = 8;
    localparam int NCP = 2;
    localparam int CMAX = 7;

    logic clk, rst_ni, flush_i;
    logic issue_valid_i, issue_ready_o;
    logic [31:0] issue_insn_i;
    logic [63:0] issue_rs1_i, issue_rs2_i;
    logic [2:0]  issue_trans_id_i;
    logic [0:0]  issue_chan_i;
    logic issue_is_ld_i, issue_is_st_i;
    logic [NCP-1:0] commit_acc_i;
    logic [NCP-1:0][2:0] commit_trans_id_i;
    logic commit_st_barrier_i;
    logic [NCH-1:0] acc_req_valid_o, acc_req_ready_i;
    logic [NCH-1:0][31:0] acc_req_insn_o;
    logic [NCH-1:0][63:0] acc_req_rs1_o, acc_req_rs2_o;
    logic [NCH-1:0][2:0]  acc_req_trans_id_o;
    logic [NCH-1:0] acc_ld_complete_i, acc_st_complete_i;
    logic cons_en_i, scalar_ld_i, scalar_st_i;
    logic scalar_stall_o, halt_o, err_o;

    acc_multi_dispatcher dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_insn_i(issue_insn_i), .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
        .issue_trans_id_i(issue_trans_id_i), .issue_chan_i(issue_chan_i),
        .issue_is_ld_i(issue_is_ld_i), .issue_is_st_i(issue_is_st_i),
        .commit_acc_i(commit_acc_i), .commit_trans_id_i(commit_trans_id_i),
        .commit_st_barrier_i(commit_st_barrier_i),
        .acc_req_valid_o(acc_req_valid_o), .acc_req_ready_i(acc_req_ready_i),
        .acc_req_insn_o(acc_req_insn_o), .acc_req_rs1_o(acc_req_rs1_o),
        .acc_req_rs2_o(acc_req_rs2_o), .acc_req_trans_id_o(acc_req_trans_id_o),
        .acc_ld_complete_i(acc_ld_complete_i), .acc_st_complete_i(acc_st_complete_i),
        .cons_en_i(cons_en_i), .scalar_ld_i(scalar_ld_i), .scalar_st_i(scalar_st_i),
        .scalar_stall_o(scalar_stall_o), .halt_o(halt_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] insn;
        logic [63:0] rs1;
        logic [63:0] rs2;
        int          tid;
        int          chan;
        bit          ld;
        bit          st;
    } ent_t;

    // reference state: queue contents, scoreboard bits, request slots, counters
    ent_t mq[$];
    bit   m_pend[NSB];
    bit   m_ns[NSB];
    bit   m_rv[NCH];
    ent_t m_req[NCH];
    int   m_cnt[4][NCH];   // 0 spec_ld, 1 spec_st, 2 disp_ld, 3 disp_st
    bit   m_halt, m_err;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < NSB; i++) begin m_pend[i] = 0; m_ns[i] = 0; end
        for (int c = 0; c < NCH; c++) begin
            m_rv[c] = 0;
            for (int k = 0; k < 4; k++) m_cnt[k][c] = 0;
        end
        m_halt = 0;
        m_err  = 0;
    endtask

    function automatic bit any_nz(input int k);
        for (int c = 0; c < NCH; c++) if (m_cnt[k][c] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic bump(input int k, input int c, input bit inc, input bit dec);
        if (inc && !dec) begin
            if (m_cnt[k][c] == CMAX) m_err = 1; else m_cnt[k][c]++;
        end else if (dec && !inc) begin
            if (m_cnt[k][c] == 0) m_err = 1; else m_cnt[k][c]--;
        end
    endtask

    task automatic compare();
        bit ldp, stp, exp_stall;
        chk("issue_ready", 64'(issue_ready_o), 64'(mq.size() < QD));
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("req_valid[%0d]", c), 64'(acc_req_valid_o[c]), 64'(m_rv[c]));
            if (m_rv[c]) begin
                chk($sformatf("req_insn[%0d]", c), 64'(acc_req_insn_o[c]), 64'(m_req[c].insn));
                chk($sformatf("req_rs1[%0d]", c), acc_req_rs1_o[c], m_req[c].rs1);
                chk($sformatf("req_rs2[%0d]", c), acc_req_rs2_o[c], m_req[c].rs2);
                chk($sformatf("req_tid[%0d]", c), 64'(acc_req_trans_id_o[c]), 64'(m_req[c].tid));
            end
        end
        ldp = any_nz(0) | any_nz(2);
        stp = any_nz(1) | any_nz(3);
        exp_stall = cons_en_i & ((scalar_ld_i & stp) | (scalar_st_i & (ldp | stp)));
        chk("scalar_stall", 64'(scalar_stall_o), 64'(exp_stall));
        chk("halt", 64'(halt_o), 64'(m_halt));
        chk("err", 64'(err_o), 64'(m_err));
    endtask

    task automatic model_step();
        bit mv, hit, fire, disp, stp;
        int mt;
        ent_t h, n;
        mv = 0; mt = 0;
        for (int p = 0; p < NCP; p++)
            if (commit_acc_i[p] && !mv) begin mv = 1; mt = int'(commit_trans_id_i[p]); end
        hit  = mv && m_pend[mt];
        fire = issue_valid_i && (mq.size() < QD) && !flush_i;
        disp = 0;
        if (mq.size() > 0 && !flush_i) begin
            h = mq[0];
            disp = (m_ns[h.tid] || (hit && mt == h.tid)) && (!m_rv[h.chan] || acc_req_ready_i[h.chan]);
        end
        stp = any_nz(1) | any_nz(3);
        m_halt = (m_halt | commit_st_barrier_i) & stp;
        for (int c = 0; c < NCH; c++) begin
            bit ic, dc;
            ic = fire && int'(issue_chan_i) == c;
            dc = disp && h.chan == c;
            bump(0, c, ic && issue_is_ld_i, dc && h.ld);
            bump(1, c, ic && issue_is_st_i, dc && h.st);
            bump(2, c, dc && h.ld, acc_ld_complete_i[c]);
            bump(3, c, dc && h.st, acc_st_complete_i[c]);
            if (acc_req_ready_i[c]) m_rv[c] = 0;
        end
        if (hit) begin m_pend[mt] = 0; m_ns[mt] = 1; end
        if (fire) begin
            n.insn = issue_insn_i; n.rs1 = issue_rs1_i; n.rs2 = issue_rs2_i;
            n.tid = int'(issue_trans_id_i); n.chan = int'(issue_chan_i);
            n.ld = issue_is_ld_i; n.st = issue_is_st_i;
            mq.push_back(n);
            m_pend[n.tid] = 1;
        end
        if (disp) begin
            m_rv[h.chan] = 1;
            m_req[h.chan] = h;
            m_ns[h.tid] = 0;
            void'(mq.pop_front());
        end
        if (flush_i) begin
            mq.delete();
            for (int i = 0; i < NSB; i++) begin m_pend[i] = 0; m_ns[i] = 0; end
            for (int c = 0; c < NCH; c++) begin m_cnt[0][c] = 0; m_cnt[1][c] = 0; end
        end
    endtask

    // inputs are driven just after the falling edge; checks and model update precede the rising edge
    task automatic tick();
        #2;
        if (rst_ni) begin
            compare();
            model_step();
        end else begin
            model_reset();
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid_i = 0; issue_is_ld_i = 0; issue_is_st_i = 0;
        commit_acc_i = '0; commit_trans_id_i = '0;
        commit_st_barrier_i = 0; flush_i = 0;
        acc_ld_complete_i = '0; acc_st_complete_i = '0;
    endtask

    task automatic issue(input int tid, input int ch, input bit ld, input bit st,
                         input logic [31:0] insn, input logic [63:0] rs1);
        issue_valid_i = 1; issue_trans_id_i = 3'(tid); issue_chan_i = 1'(ch);
        issue_is_ld_i = ld; issue_is_st_i = st; issue_insn_i = insn;
        issue_rs1_i = rs1; issue_rs2_i = {rs1[31:0], rs1[63:32]};
    endtask

    task automatic mark(input int tid);
        commit_acc_i = 2'b01;
        commit_trans_id_i[0] = 3'(tid);
    endtask

    initial begin
        rst_ni = 0; idle();
        issue_insn_i = '0; issue_rs1_i = '0; issue_rs2_i = '0;
        issue_trans_id_i = '0; issue_chan_i = '0;
        acc_req_ready_i = 2'b11; cons_en_i = 1; scalar_ld_i = 1; scalar_st_i = 1;
        @(negedge clk); #1;
        tick(); tick();
        rst_ni = 1;
        chk("rst_ready", 64'(issue_ready_o), 64'd1);
        chk("rst_valid", 64'(acc_req_valid_o), 64'd0);
        chk("rst_stall", 64'(scalar_stall_o), 64'd0);
        chk("rst_halt", 64'(halt_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        cons_en_i = 0; scalar_ld_i = 0; scalar_st_i = 0;
        tick();

        // basic latency
        issue(3, 1, 0, 0, 32'hA5A5_0003, 64'h1111_2222_3333_0003); tick();
        idle(); mark(3); tick();
        chk("lat_valid", 64'(acc_req_valid_o[1]), 64'd1);
        chk("lat_insn", 64'(acc_req_insn_o[1]), 64'hA5A5_0003);
        chk("lat_rs1", acc_req_rs1_o[1], 64'h1111_2222_3333_0003);
        chk("lat_tid", 64'(acc_req_trans_id_o[1]), 64'd3);
        idle(); tick();
        chk("lat_drop", 64'(acc_req_valid_o[1]), 64'd0);

        // head-of-line blocking
        issue(1, 0, 0, 0, 32'h0000_0101, 64'h10); tick();
        issue(2, 1, 0, 0, 32'h0000_0202, 64'h20); tick();
        idle(); mark(2); tick();
        idle(); tick();
        chk("hol_none", 64'(acc_req_valid_o), 64'd0);
        mark(1); tick();
        chk("hol_first", 64'(acc_req_valid_o), 64'b01);
        chk("hol_first_tid", 64'(acc_req_trans_id_o[0]), 64'd1);
        idle(); tick();
        chk("hol_second", 64'(acc_req_valid_o), 64'b10);
        chk("hol_second_tid", 64'(acc_req_trans_id_o[1]), 64'd2);
        tick();

        // fill then flush
        cons_en_i = 1; scalar_st_i = 1;
        issue(4, 0, 1, 0, 32'h44, 64'h4); tick();
        issue(5, 1, 0, 1, 32'h55, 64'h5); tick();
        issue(6, 0, 1, 0, 32'h66, 64'h6); tick();
        issue(7, 1, 0, 0, 32'h77, 64'h7); tick();
        chk("fl_full", 64'(issue_ready_o), 64'd0);
        chk("fl_stall_pre", 64'(scalar_stall_o), 64'd1);
        issue(0, 0, 1, 0, 32'h88, 64'h8); tick();
        flush_i = 1; tick();
        idle();
        chk("fl_ready", 64'(issue_ready_o), 64'd1);
        chk("fl_valid", 64'(acc_req_valid_o), 64'd0);
        chk("fl_stall_post", 64'(scalar_stall_o), 64'd0);
        tick();
        scalar_st_i = 0;

        // scalar stall on an outstanding store
        scalar_ld_i = 1;
        issue(0, 0, 0, 1, 32'hC0, 64'hC0); tick();
        chk("ss_spec", 64'(scalar_stall_o), 64'd1);
        idle(); mark(0); tick();
        idle(); tick(); tick();
        chk("ss_hold", 64'(scalar_stall_o), 64'd1);
        acc_st_complete_i = 2'b01; tick();
        idle();
        chk("ss_release", 64'(scalar_stall_o), 64'd0);
        tick();
        cons_en_i = 0;
        issue(1, 0, 0, 1, 32'hC1, 64'hC1); tick();
        chk("ss_off", 64'(scalar_stall_o), 64'd0);
        idle(); mark(1); tick();
        idle(); tick();
        acc_st_complete_i = 2'b01; tick();
        idle(); tick();
        scalar_ld_i = 0;

        // store barrier
        issue(2, 0, 0, 1, 32'hD2, 64'hD2); tick();
        issue(3, 1, 0, 1, 32'hD3, 64'hD3); tick();
        idle(); mark(2); tick();
        idle(); mark(3); tick();
        idle(); tick();
        commit_st_barrier_i = 1; tick();
        idle();
        chk("bar_halt", 64'(halt_o), 64'd1);
        tick(); tick();
        chk("bar_hold", 64'(halt_o), 64'd1);
        acc_st_complete_i = 2'b01; tick();
        idle();
        chk("bar_one_left", 64'(halt_o), 64'd1);
        acc_st_complete_i = 2'b10; tick();
        idle();
        chk("bar_last", 64'(halt_o), 64'd1);
        tick();
        chk("bar_clear", 64'(halt_o), 64'd0);

        // back-to-back on one channel, then backpressure
        issue(5, 0, 0, 0, 32'hE5, 64'hE5); tick();
        issue(6, 0, 0, 0, 32'hE6, 64'hE6); mark(5); tick();
        chk("b2b_a", 64'(acc_req_trans_id_o[0]), 64'd5);
        issue(7, 0, 0, 0, 32'hE7, 64'hE7); mark(6); tick();
        chk("b2b_b", 64'(acc_req_trans_id_o[0]), 64'd6);
        idle(); mark(7); acc_req_ready_i = 2'b10; tick();
        idle();
        chk("b2b_hold_valid", 64'(acc_req_valid_o[0]), 64'd1);
        chk("b2b_hold_tid", 64'(acc_req_trans_id_o[0]), 64'd6);
        tick();
        acc_req_ready_i = 2'b11; tick();
        chk("b2b_c", 64'(acc_req_trans_id_o[0]), 64'd7);
        tick();

        // underflow error is sticky until reset
        acc_ld_complete_i = 2'b10; tick();
        idle();
        chk("err_set", 64'(err_o), 64'd1);
        tick(); tick();
        chk("err_sticky", 64'(err_o), 64'd1);
        rst_ni = 0; tick();
        rst_ni = 1;
        chk("err_reset", 64'(err_o), 64'd0);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/acc_multi_dispatcher.md
# acc_multi_dispatcher

Parametrised successor of the single-channel accelerator dispatcher. It accepts accelerator instructions from the issue stage into an in-order queue, holds each one until the scoreboard marks it non-speculative, and routes it to one of `NrChannels` accelerator request ports. Per channel, it tracks speculative and dispatched loads and stores to stall scalar memory operations and to hold store barriers. It sits between issue/commit and the accelerator interconnect.

## Interface
Parameters:
- `NrChannels`, 2: number of accelerator request channels; `ChW = max(1, $clog2(NrChannels))`.
- `QueueDepth`, 4: instruction queue entries, ≥2.
- `NrSbEntries`, 8: scoreboard entries; `TransIdBits = $clog2(NrSbEntries)`.
- `NrCommitPorts`, 2: commit ports scanned for the non-speculative marker.
- `CntWidth`, 3: width of each load/store counter.
- `XLEN`, 64: operand width.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i` in 1: clock.
- `rst_ni` in 1: async active-low reset.
- `flush_i` in 1: flush all speculative state.
- `issue_valid_i` in 1, `issue_ready_o` out 1: issue handshake.
- `issue_insn_i` in 32, `issue_rs1_i`/`issue_rs2_i` in XLEN, `issue_trans_id_i` in TransIdBits, `issue_chan_i` in ChW, `issue_is_ld_i`/`issue_is_st_i` in 1: instruction fields.
- `commit_acc_i` in NrCommitPorts: port p holds an unexecuted accelerator instruction at the commit head.
- `commit_trans_id_i` in NrCommitPorts×TransIdBits: trans ID per commit port.
- `commit_st_barrier_i` in 1: a store barrier committed.
- `acc_req_valid_o` out NrChannels, `acc_req_ready_i` in NrChannels: per-channel request handshake.
- `acc_req_insn_o` out NrChannels×32, `acc_req_rs1_o`/`acc_req_rs2_o` out NrChannels×XLEN, `acc_req_trans_id_o` out NrChannels×TransIdBits: per-channel request data.
- `acc_ld_complete_i`/`acc_st_complete_i` in NrChannels: one load/store retired by a channel.
- `cons_en_i` in 1: memory-consistent mode.
- `scalar_ld_i`/`scalar_st_i` in 1: a scalar load/store is at issue.
- `scalar_stall_o` out 1: stall that scalar op.
- `halt_o` out 1: halt at store barrier.
- `err_o` out 1: sticky counter over/underflow.

## Operation
- **Issue:** the issue handshake fires when `issue_valid_i & issue_ready_o & ~flush_i`. The entry is pushed into the FIFO and `pending[trans_id]` is set. `issue_ready_o = usage < QueueDepth`.
- **Marker:** the marker port is the lowest p with `commit_acc_i[p]`. If `pending_q[tid_p]` is set, it is cleared and `nonspec[tid_p]` is set.
- **Head dispatchable:** requires the queue to be non-empty, plus `nonspec_q[head.tid]` or a same-cycle marker hit on `head.tid`, plus channel `head.chan` request register either empty or handshaking this cycle.
- **Dispatch:** pops the head, loads that channel's register, and clears `nonspec[head.tid]`. At most one dispatch per cycle.
- **Ordering:**
  - Head-of-line blocking is required: a blocked head stalls all channels.
  - Each request register holds valid and data stable until `acc_req_ready_i[c]`.
- **Counters:**
  - `spec_ld/spec_st[c]`: increment on issue to c, decrement on dispatch, cleared by `flush_i`.
  - `disp_ld/disp_st[c]`: increment on dispatch, decrement on `*_complete_i[c]`, not flushed.
  - Simultaneous increment and decrement leave the count unchanged.
  - Increment at max saturates; decrement at 0 holds. Either case sets `err_o` until reset.
- **Scalar stall:**
  - `ldp` = any ld counter ≠0; `stp` = any st counter ≠0.
  - `scalar_stall_o = cons_en_i & ((scalar_ld_i & stp) | (scalar_st_i & (ldp|stp)))`.
- **Barrier:** `halt_d = (halt_q | commit_st_barrier_i) & stp`; `halt_o = halt_q`.
- **Flush:** clears the queue, `pending`, `nonspec` and the spec counters. It does not touch request registers or disp counters. The controller asserts flush only when no non-speculative entry is undispatched. A same-cycle issue is dropped.
- **Reset values:** all valids 0, `issue_ready_o` 1, `halt_o` 0, `err_o` 0, `scalar_stall_o` 0, all counters and bit vectors 0.

## Timing
- The queue is not fall-through: an entry pushed in cycle t is at the head in t+1.
- The request register is a plain register: dispatch in t gives `acc_req_valid_o` in t+1.
- Minimum issue-to-request latency is 2 cycles.
- Back-to-back dispatches to one channel sustain 1 per cycle while `acc_req_ready_i` is held high.
- Counter and halt updates are visible the cycle after the event.
- `scalar_stall_o` is combinational on current counter state.

## Structure
- `acc_pkg` gains `acc_disp_entry_t` {insn, rs1, rs2, trans_id, chan, is_ld, is_st}.
- The queue reuses the common_cells `fifo_v3` with `FALL_THROUGH=0`.
- One new sub-module, `acc_sat_counter` (params `WIDTH`; ports `clr_i`, `inc_i`, `dec_i`, `q_o`, `err_o`), is instantiated 4×NrChannels.

## Test plan
- **Basic latency:** issue tid 3 to chan 1 at t, marker tid 3 at t+1, ready high → `acc_req_valid_o[1]` at t+2 with matching insn/rs1/tid, then low at t+3.
- **Head-of-line blocking:** issue tid 1 (chan 0) and tid 2 (chan 1); mark only tid 2 → no dispatch; mark tid 1 → dispatches in order 1 then 2.
- **Flush:** fill queue (4 entries), `issue_ready_o`=0; `flush_i` → next cycle `issue_ready_o`=1, spec counters 0, no request valid.
- **Scalar stall:** `cons_en_i`=1, dispatch a store on chan 0 → `scalar_ld_i` stalls until `acc_st_complete_i[0]`; with `cons_en_i`=0 → never stalls.
- **Store barrier:** dispatch 2 stores, `commit_st_barrier_i` → `halt_o`=1 from the next cycle until the second `acc_st_complete_i`, then 0 one cycle later.
- **Counter error:** with `CntWidth`=3, `acc_ld_complete_i[1]` pulsed with counter at 0 → count stays 0 and `err_o`=1 until reset.
